// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART FSM states and baud arithmetic for uart_tx/uart_rx
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // 16x oversampling divisor, identical on both ends of the link
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / (baud_rate * 16);
  endfunction

  // clocks per serial bit
  function automatic int bit_cycles(input int clk_freq, input int baud_rate);
    return baud_div(clk_freq, baud_rate) * 16;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with synchronous clear and bit_done pulse
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD_RATE);
  localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // count 0..BIT_CYCLES-1 and wrap; held at zero while cleared
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_done = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter, 8E1 when UART_TX_PARITY_EN is defined
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx
);

  uart_state_t state, state_next;
  logic [7:0]  shreg, shreg_next;
  logic [2:0]  idx, idx_next;
  logic        tx_next;
  logic        bit_done;
  logic        baud_clear;
  logic        accept;
`ifdef UART_TX_PARITY_EN
  logic        par, par_next;
`endif

  assign tx_ready   = (state == IDLE) && tx_en;
  assign tx_busy    = (state != IDLE);
  assign accept     = tx_valid && tx_ready;
  assign baud_clear = (state == IDLE);

  uart_baud_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (baud_clear),
    .bit_done (bit_done)
  );

  // next state, shift register and the line level that goes with the next state
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    idx_next   = idx;
    tx_next    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_next   = par;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = START;
          shreg_next = tx_data;
          idx_next   = 3'd0;
`ifdef UART_TX_PARITY_EN
          par_next   = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shreg_next = {1'b0, shreg[7:1]};
          idx_next   = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // the line is registered, so it is derived from where the FSM goes next
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = par_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  // state, datapath and registered line output
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= 8'h00;
      idx   <= 3'd0;
      tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      idx   <= idx_next;
      tx    <= tx_next;
`ifdef UART_TX_PARITY_EN
      par   <= par_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx, 8N1 or 8E1 with UART_TX_PARITY_EN
module tb_uart_tx;

  // 4.8 MHz / (100 kbaud * 16) = 3, so 48 clocks per bit
  localparam int BC = 48;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BC;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_en;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_hold = 1'b0;
  bit   mon_busy = 1'b0;
  exp_t sb[$];

  uart_tx #(
    .CLK_FREQ  (4_800_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_en    (tx_en),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit keep, output int n);
    n = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    while (tx_ready !== 1'b1 && n < 15 * BC) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready !== 1'b1) begin
      check("send_timeout", 32'(n < 15 * BC), 32'd1);
      tx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      tx_data = d ^ 8'h5A;
      if (!keep) tx_valid = 1'b0;
      @(negedge clk);
      check("start_bit", 32'(tx), 32'd0);
      check("busy_after_accept", 32'(tx_busy), 32'd1);
      check("ready_after_accept", 32'(tx_ready), 32'd0);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < 15 * BC) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(tx_busy), 32'd0);
  endtask

  // monitor: decode every frame on the line and compare against the scoreboard
  initial begin : monitor
    exp_t       e;
    logic [7:0] d;
    logic       pb;
    logic       bitv;
    logic       shape_ok;
    int         s_cyc;
    int         last_end;
    bit         have_last;
    have_last = 1'b0;
    last_end  = 0;
    forever begin
      @(negedge clk);
      if (!mon_hold && tx === 1'b0) begin
        mon_busy = 1'b1;
        s_cyc    = cyc;
        shape_ok = 1'b1;
        d        = 8'h00;
        pb       = 1'b0;
        bitv     = 1'b0;
        for (int b = 0; b < NBITS; b++) begin
          for (int c = 0; c < BC; c++) begin
            if (b > 0 || c > 0) @(negedge clk);
            if (c == 0) bitv = tx;
            if (tx !== bitv) shape_ok = 1'b0;
          end
          if (b == 0 && bitv !== 1'b0) shape_ok = 1'b0;
          if (b >= 1 && b <= 8) d[b-1] = bitv;
          if (b == 9 && NBITS == 11) pb = bitv;
          if (b == NBITS - 1 && bitv !== 1'b1) shape_ok = 1'b0;
        end
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame got %0h expected none", d);
        end else begin
          e = sb.pop_front();
          check("frame_data", 32'(d), 32'(e.data));
          check("frame_shape", 32'(shape_ok), 32'd1);
`ifdef UART_TX_PARITY_EN
          check("frame_parity", 32'(pb), 32'(e.par));
`endif
          if (e.gap >= 0) begin
            check("frame_gap", have_last ? 32'(s_cyc - last_end - 1) : 32'hFFFF_FFFF, 32'(e.gap));
          end
        end
        last_end  = cyc;
        have_last = 1'b1;
        mon_busy  = 1'b0;
      end
    end
  end

  // stimulus
  initial begin : stim
    int n;
    bit ok;
    reset    = 1'b1;
    tx_en    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    reset = 1'b0;
    ok = 1'b1;
    repeat (2000) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
    end
    check("idle_high", 32'(ok), 32'd1);

    sb.push_back('{8'hA5, 1'b0, -1});
    send_byte(8'hA5, 1'b0, n);
    wait_idle();

    tx_en    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h81;
    ok = 1'b1;
    repeat (2000) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_ready !== 1'b0 || tx_busy !== 1'b0) ok = 1'b0;
    end
    check("en_gate_start", 32'(ok), 32'd1);
    tx_valid = 1'b0;
    tx_en    = 1'b1;

    sb.push_back('{8'h00, 1'b0, -1});
    sb.push_back('{8'hFF, 1'b0, 1});
    send_byte(8'h00, 1'b1, n);
    send_byte(8'hFF, 1'b0, n);
    check("b2b_frame_len", 32'(n), 32'(FRAME - 1));
    wait_idle();

    sb.push_back('{8'h3C, 1'b0, -1});
    send_byte(8'h3C, 1'b0, n);
    repeat (3 * BC) @(negedge clk);
    tx_en    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    wait_idle();
    ok = 1'b1;
    repeat (4 * BC) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_ready !== 1'b0 || tx_busy !== 1'b0) ok = 1'b0;
    end
    check("en_drop_no_frame", 32'(ok), 32'd1);
    tx_valid = 1'b0;
    tx_en    = 1'b1;

    mon_hold = 1'b1;
    send_byte(8'h55, 1'b0, n);
    repeat (5 * BC + BC / 2) @(negedge clk);
    check("pre_reset_busy", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    mon_hold = 1'b0;
    sb.push_back('{8'h55, 1'b0, -1});
    send_byte(8'h55, 1'b0, n);
    wait_idle();

    sb.push_back('{8'h07, 1'b1, -1});
    sb.push_back('{8'h03, 1'b0, -1});
    send_byte(8'h07, 1'b0, n);
    send_byte(8'h03, 1'b0, n);
    check("frame_len", 32'(n), 32'(FRAME - 1));

    n = 0;
    while ((sb.size() > 0 || mon_busy) && n < 20 * BC) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
